img_mem_arbiter: RTL and testbench



---
 rtl/img_mem_pkg.sv | 44 ++++
 rtl/req_age_counter.sv | 29 ++
 rtl/img_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_img_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_mem_pkg.sv
// Shared ids and priority order for the image RAM requesters.
// Also used by vga_control and line_buffers.
package img_mem_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        REQ_CAM  = 2'd0,
        REQ_BUF  = 2'd1,
        REQ_CONV = 2'd2,
        REQ_HPS  = 2'd3
    } req_id_e;

    // Highest priority first.
    localparam req_id_e PRIO_ORDER [NUM_REQ] = '{
        REQ_CAM, REQ_BUF, REQ_CONV, REQ_HPS
    };

    // Read tag travelling alongside the RAM access.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    // cam and conv only write; buf and hps only read.
    function automatic logic is_write(input req_id_e id);
        return (id == REQ_CAM) || (id == REQ_CONV);
    endfunction

    // Highest-priority requester present in vec.
    function automatic req_id_e pick_id(
        input logic [NUM_REQ-1:0] vec
    );
        req_id_e w;
        w = REQ_CAM;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[PRIO_ORDER[i]]) begin
                w = PRIO_ORDER[i];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/req_age_counter.sv
// Saturating wait counter for one requester.
// Raises urgent once the request has waited MAX_WAIT cycles.
module req_age_counter #(
    parameter int MAX_WAIT  = 63,
    parameter bit URGENT_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic urgent
);

    localparam logic [7:0] SAT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    // Count waiting cycles; any grant or dropped request restarts aging.
    always_ff @(posedge clk) begin
        if (reset || !req || gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != SAT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign urgent = URGENT_EN && req && (wait_cnt == SAT);

endmodule

// File: rtl/img_mem_arbiter.sv
// Single-port image RAM arbiter with aging and read tagging.
// Grants combinationally, drives a registered RAM port.
module img_mem_arbiter
    import img_mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_req,
    input  logic              conv_req,
    input  logic              buf_req,
    input  logic              hps_req,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [ADDR_W-1:0] conv_addr,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [ADDR_W-1:0] hps_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    input  logic [DATA_W-1:0] conv_wdata,
    output logic              cam_gnt,
    output logic              conv_gnt,
    output logic              buf_gnt,
    output logic              hps_gnt,
    output logic              buf_rvalid,
    output logic              hps_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] urg_v;
    logic [NUM_REQ-1:0] gnt_v;
    logic               any_gnt;
    req_id_e            win_id;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_we;
    logic               inflight;
    rd_tag_t            tag_q [RD_LAT+1];

    assign req_v[REQ_CAM]  = cam_req;
    assign req_v[REQ_BUF]  = buf_req;
    assign req_v[REQ_CONV] = conv_req;
    assign req_v[REQ_HPS]  = hps_req;

    // The camera stream is never aged: it already wins on base priority.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        req_age_counter #(
            .MAX_WAIT  (MAX_WAIT),
            .URGENT_EN (i != 0)
        ) u_age (
            .clk    (clk),
            .reset  (reset),
            .req    (req_v[i]),
            .gnt    (gnt_v[i]),
            .urgent (urg_v[i])
        );
    end

    // Urgent requesters pre-empt the rest; base priority breaks ties.
    always_comb begin
        win_id  = pick_id((|urg_v) ? urg_v : req_v);
        any_gnt = !reset && (|req_v);
        gnt_v   = '0;
        if (any_gnt) begin
            gnt_v[win_id] = 1'b1;
        end
    end

    // Route the winner's address and data to the RAM port.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        unique case (win_id)
            REQ_CAM: begin
                win_addr  = cam_addr;
                win_wdata = cam_wdata;
            end
            REQ_BUF: begin
                win_addr  = buf_addr;
            end
            REQ_CONV: begin
                win_addr  = conv_addr;
                win_wdata = conv_wdata;
            end
            REQ_HPS: begin
                win_addr  = hps_addr;
            end
        endcase
        win_we = is_write(win_id);
    end

    assign cam_gnt  = gnt_v[REQ_CAM];
    assign buf_gnt  = gnt_v[REQ_BUF];
    assign conv_gnt = gnt_v[REQ_CONV];
    assign hps_gnt  = gnt_v[REQ_HPS];

    // Registered RAM port; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= any_gnt && win_we;
            if (any_gnt) begin
                mem_addr <= win_addr;
                if (win_we) begin
                    mem_wdata <= win_wdata;
                end
            end
        end
    end

    // Tag pipe: stage 0 aligns with mem_addr, last stage with rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= any_gnt && !win_we;
            tag_q[0].id    <= win_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Capture RAM output in the cycle the tagged read lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (tag_q[RD_LAT-1].valid) begin
            rdata <= mem_rdata;
        end
    end

    assign buf_rvalid = tag_q[RD_LAT].valid &&
                        (tag_q[RD_LAT].id == REQ_BUF);
    assign hps_rvalid = tag_q[RD_LAT].valid &&
                        (tag_q[RD_LAT].id == REQ_HPS);

    // A read counts as in flight until its data is presented.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight | tag_q[i].valid;
        end
    end

    assign busy = !reset && ((|req_v) || inflight);

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: directed tables, corner sequences,
// and a randomized run against a behavioural arbitration model.
module tb_img_mem_arbiter;
    import img_mem_pkg::*;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int MAXW   = 4;
    localparam int NRAND  = 10000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_req = 0, conv_req = 0;
    logic          buf_req = 0, hps_req = 0;
    logic [AW-1:0] cam_addr = 0, conv_addr = 0;
    logic [AW-1:0] buf_addr = 0, hps_addr = 0;
    logic [DW-1:0] cam_wdata = 0, conv_wdata = 0;
    logic          cam_gnt, conv_gnt, buf_gnt, hps_gnt;
    logic          buf_rvalid, hps_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = 0;
    logic          busy;
    logic [3:0]    gv;

    always #5 clk = ~clk;

    img_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .RD_LAT(RD_LAT), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .reset(reset),
        .cam_req(cam_req), .conv_req(conv_req),
        .buf_req(buf_req), .hps_req(hps_req),
        .cam_addr(cam_addr), .conv_addr(conv_addr),
        .buf_addr(buf_addr), .hps_addr(hps_addr),
        .cam_wdata(cam_wdata), .conv_wdata(conv_wdata),
        .cam_gnt(cam_gnt), .conv_gnt(conv_gnt),
        .buf_gnt(buf_gnt), .hps_gnt(hps_gnt),
        .buf_rvalid(buf_rvalid), .hps_rvalid(hps_rvalid),
        .rdata(rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign gv = {hps_gnt, conv_gnt, buf_gnt, cam_gnt};

    // RAM model: unwritten words read as {A5A5, addr}; RD_LAT=1 means
    // mem_rdata follows the registered address within the same cycle.
    logic [DW-1:0] ram [logic [AW-1:0]];
    logic [DW-1:0] mm  [logic [AW-1:0]];

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return {16'hA5A5, a};
    endfunction

    function automatic logic [DW-1:0] mm_rd(input logic [AW-1:0] a);
        if (mm.exists(a)) return mm[a];
        return {16'hA5A5, a};
    endfunction

    always begin
        @(posedge clk);
        if (mem_we) ram[mem_addr] = mem_wdata;
        #1;
        mem_rdata = ram_rd(mem_addr);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp);
        end
    endtask

    logic [3:0]    rq_v = 0;
    logic [AW-1:0] ra [4];
    logic [DW-1:0] rw [4];

    task automatic put();
        cam_req  = rq_v[0]; cam_addr  = ra[0]; cam_wdata  = rw[0];
        buf_req  = rq_v[1]; buf_addr  = ra[1];
        conv_req = rq_v[2]; conv_addr = ra[2]; conv_wdata = rw[2];
        hps_req  = rq_v[3]; hps_addr  = ra[3];
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".gnt"}, 64'(gv), 0);
        chk({tag, ".buf_rv"}, 64'(buf_rvalid), 0);
        chk({tag, ".hps_rv"}, 64'(hps_rvalid), 0);
        chk({tag, ".we"}, 64'(mem_we), 0);
        chk({tag, ".addr"}, 64'(mem_addr), 0);
        chk({tag, ".wdata"}, 64'(mem_wdata), 0);
        chk({tag, ".rdata"}, 64'(rdata), 0);
        chk({tag, ".busy"}, 64'(busy), 0);
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    vec_t tbl [10];
    rd_t  rdq [$];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            ra[i] = 0;
            rw[i] = 0;
        end
        // bit order {hps, conv, buf, cam}
        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0001};
        tbl[2] = '{4'b1110, 4'b0010};
        tbl[3] = '{4'b1100, 4'b0100};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b1010, 4'b0010};
        tbl[6] = '{4'b0101, 4'b0001};
        tbl[7] = '{4'b0000, 4'b0000};
        tbl[8] = '{4'b1101, 4'b0001};
        tbl[9] = '{4'b0110, 4'b0010};

        // All four requesting across reset release.
        ra[0] = 16'h0010; rw[0] = 32'hC0C0_0010;
        ra[1] = 16'h0020;
        ra[2] = 16'h0030; rw[2] = 32'hC0DE_0030;
        ra[3] = 16'h0040;
        rq_v = 4'b1111;
        put();
        drv(); drv();
        smp();
        chk_rst("rst");
        drv(); reset = 1'b0;
        smp();
        chk("all4.g0", 64'(gv), 4'b0001);
        drv(); rq_v[0] = 0; put();
        smp();
        chk("all4.g1", 64'(gv), 4'b0010);
        chk("all4.we1", 64'(mem_we), 1);
        chk("all4.a1", 64'(mem_addr), 16'h0010);
        chk("all4.d1", 64'(mem_wdata), 32'hC0C0_0010);
        drv(); rq_v[1] = 0; put();
        smp();
        chk("all4.g2", 64'(gv), 4'b0100);
        chk("all4.we2", 64'(mem_we), 0);
        chk("all4.a2", 64'(mem_addr), 16'h0020);
        drv(); rq_v[2] = 0; put();
        smp();
        chk("all4.g3", 64'(gv), 4'b1000);
        chk("all4.a3", 64'(mem_addr), 16'h0030);
        chk("all4.d3", 64'(mem_wdata), 32'hC0DE_0030);
        chk("all4.brv", 64'(buf_rvalid), 1);
        chk("all4.brd", 64'(rdata), 32'hA5A5_0020);
        drv(); rq_v[3] = 0; put();
        smp();
        chk("all4.g4", 64'(gv), 0);
        chk("all4.a4", 64'(mem_addr), 16'h0040);
        chk("all4.busy4", 64'(busy), 1);
        chk("all4.hrv4", 64'(hps_rvalid), 0);
        drv();
        smp();
        chk("all4.hrv5", 64'(hps_rvalid), 1);
        chk("all4.hrd5", 64'(rdata), 32'hA5A5_0040);
        chk("all4.busy5", 64'(busy), 0);

        // Single-cycle priority table.
        for (int i = 0; i < 4; i++) ra[i] = 16'h0100 + 16'(i);
        for (int k = 0; k < 10; k++) begin
            drv(); rq_v = tbl[k].req; put();
            smp();
            chk($sformatf("tbl%0d", k), 64'(gv), 64'(tbl[k].gnt));
            drv(); rq_v = 0; put();
        end
        drv(); drv();

        // Single buf read.
        drv(); rq_v = 4'b0010; ra[1] = 16'h0040; put();
        smp();
        chk("rd.gnt", 64'(gv), 4'b0010);
        drv(); rq_v = 0; put();
        smp();
        chk("rd.addr", 64'(mem_addr), 16'h0040);
        chk("rd.we", 64'(mem_we), 0);
        chk("rd.rv1", 64'(buf_rvalid), 0);
        drv();
        smp();
        chk("rd.rv2", 64'(buf_rvalid), 1);
        chk("rd.data", 64'(rdata), 32'hA5A5_0040);
        chk("rd.hrv", 64'(hps_rvalid), 0);

        // Read after write, consecutive grants.
        drv();
        rq_v = 4'b0100; ra[2] = 16'h1234; rw[2] = 32'h0000_00FF;
        put();
        smp();
        chk("raw.wg", 64'(gv), 4'b0100);
        drv(); rq_v = 4'b0010; ra[1] = 16'h1234; put();
        smp();
        chk("raw.rg", 64'(gv), 4'b0010);
        chk("raw.we", 64'(mem_we), 1);
        chk("raw.d", 64'(mem_wdata), 32'h0000_00FF);
        drv(); rq_v = 0; put();
        drv();
        smp();
        chk("raw.rv", 64'(buf_rvalid), 1);
        chk("raw.data", 64'(rdata), 32'h0000_00FF);

        // Aging against a continuous camera stream.
        ra[0] = 16'h0300; rw[0] = 32'h1111_2222; ra[3] = 16'h0301;
        for (int k = 0; k < 6; k++) begin
            drv();
            if (k == 0) rq_v = 4'b1001;
            if (k == 5) rq_v[3] = 0;
            put();
            smp();
            chk($sformatf("age%0d", k), 64'(gv),
                (k == 4) ? 64'h8 : 64'h1);
        end
        drv(); rq_v = 0; put();
        drv(); drv(); drv();

        // Reset one cycle after an hps grant flushes the read.
        drv(); rq_v = 4'b1000; ra[3] = 16'h0077; put();
        smp();
        chk("flush.gnt", 64'(gv), 4'b1000);
        drv(); rq_v = 0; put(); reset = 1'b1;
        smp();
        chk("flush.g1", 64'(gv), 0);
        drv();
        smp();
        chk_rst("flush");
        drv(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("flush.hrv%0d", k), 64'(hps_rvalid), 0);
            drv();
        end

        // Randomized traffic against the reference model.
        begin
            int            wm [4];
            int            waited [4];
            logic [3:0]    last_g, urg, cand, eg;
            logic [1:0]    exp_rv;
            logic [DW-1:0] exp_d;
            logic          prev_any, prev_we, issue, done;
            logic [AW-1:0] prev_a, hold_a;
            logic [DW-1:0] prev_d;
            int            rd_gnt, rv_cnt, id;
            for (int i = 0; i < 4; i++) begin
                wm[i] = 0;
                waited[i] = 0;
            end
            last_g = 0; prev_any = 0; prev_we = 0;
            prev_a = 0; hold_a = 0; prev_d = 0;
            rd_gnt = 0; rv_cnt = 0; done = 0; id = 0;
            for (int c = 0; c < NRAND + 300; c++) begin
                issue = (c < NRAND);
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    if (!rq_v[i] || last_g[i]) begin
                        if (issue && $urandom_range(0, 99) < 45) begin
                            rq_v[i] = 1;
                            ra[i] = 16'h0200 + 16'($urandom_range(0, 31));
                            rw[i] = $urandom;
                        end else begin
                            rq_v[i] = 0;
                        end
                    end
                end
                put();
                @(negedge clk);
                urg = 0;
                for (int i = 1; i < 4; i++)
                    urg[i] = rq_v[i] && (wm[i] == MAXW);
                cand = (urg != 0) ? urg : rq_v;
                eg = 0;
                for (int i = 3; i >= 0; i--)
                    if (cand[i]) begin
                        eg = 4'(1 << i);
                        id = i;
                    end
                chk($sformatf("rnd%0d.gnt", c), 64'(gv), 64'(eg));
                exp_rv = 0; exp_d = 0;
                if (rdq.size() > 0 && rdq[0].due == c) begin
                    exp_rv = (rdq[0].id == int'(REQ_BUF)) ? 2'b01 : 2'b10;
                    exp_d = rdq[0].data;
                    void'(rdq.pop_front());
                end
                chk($sformatf("rnd%0d.rv", c),
                    64'({hps_rvalid, buf_rvalid}), 64'(exp_rv));
                if (exp_rv != 0)
                    chk($sformatf("rnd%0d.rdata", c), 64'(rdata),
                        64'(exp_d));
                rv_cnt += int'(buf_rvalid) + int'(hps_rvalid);
                if (prev_any) begin
                    chk($sformatf("rnd%0d.we", c), 64'(mem_we),
                        64'(prev_we));
                    chk($sformatf("rnd%0d.addr", c), 64'(mem_addr),
                        64'(prev_a));
                    if (prev_we)
                        chk($sformatf("rnd%0d.wd", c), 64'(mem_wdata),
                            64'(prev_d));
                    hold_a = prev_a;
                end else begin
                    chk($sformatf("rnd%0d.we0", c), 64'(mem_we), 0);
                    chk($sformatf("rnd%0d.hold", c), 64'(mem_addr),
                        64'(hold_a));
                end
                prev_any = (eg != 0);
                if (prev_any) begin
                    prev_a = ra[id];
                    prev_we = (id == 0) || (id == 2);
                    prev_d = rw[id];
                    if (prev_we) begin
                        mm[prev_a] = prev_d;
                    end else begin
                        rdq.push_back('{c + 1 + RD_LAT, id, mm_rd(prev_a)});
                        rd_gnt++;
                    end
                    if (id != 0)
                        chk($sformatf("rnd%0d.wait%0d", c, id),
                            64'(waited[id] > MAXW + 3), 0);
                end
                for (int i = 0; i < 4; i++) begin
                    if (eg[i] || !rq_v[i]) begin
                        wm[i] = 0;
                        waited[i] = 0;
                    end else begin
                        wm[i] = (wm[i] < MAXW) ? wm[i] + 1 : MAXW;
                        waited[i]++;
                    end
                end
                last_g = gv;
                if (!issue && rq_v == 0 && rdq.size() == 0 &&
                    !prev_any) begin
                    done = 1;
                    break;
                end
            end
            chk("rnd.drain", 64'(done), 1);
            chk("rnd.rv_count", 64'(rv_cnt), 64'(rd_gnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
